bwt_param_scheduler: RTL and testbench

Parameter-side responder for the accelerator's top-level state controller: it consumes the 3-bit `state` code and produces the controller's `is_start`, `is_find`, `is_get_data_in_Occ` and `is_finish` inputs. It holds a small table of backward-search tasks. Each task is a read index `i` plus an SA interval `[k, l]`. The block hands tasks out round-robin during GET_PARAM, captures updated values during WRITE_BACK, and reports completion when every loaded task is done. The host loads the task table before start and reads it back after completion.

---
 rtl/bwt_param_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_bwt_param_scheduler.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bwt_param_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : bwt_param_scheduler
//  Description : Task-table responder for the BWT backward-search controller.
//                Hands out pending (i, k, l) tasks round-robin in GET_PARAM,
//                stores the EX results in WRITE_BACK and signals completion
//                once every loaded task is done.
//  Revision    : 1.0 - initial release
// ============================================================================
module bwt_param_scheduler #(
  parameter int NUM_SLOT = 8,
  parameter int I_W      = 7,
  parameter int SA_W     = 32,
  localparam int SLOT_W  = $clog2(NUM_SLOT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        state,
  // host table load
  input  logic              load_en,
  input  logic [SLOT_W-1:0] load_slot,
  input  logic [I_W-1:0]    load_i,
  input  logic [SA_W-1:0]   load_k,
  input  logic [SA_W-1:0]   load_l,
  input  logic              start_req,
  // results from the EX stage
  input  logic [I_W-1:0]    wb_i,
  input  logic [SA_W-1:0]   wb_k,
  input  logic [SA_W-1:0]   wb_l,
  input  logic              wb_done,
  // controller status inputs
  output logic              is_start,
  output logic              is_find,
  output logic              is_get_data_in_Occ,
  output logic              is_finish,
  // task in flight
  output logic [SLOT_W-1:0] cur_slot,
  output logic [I_W-1:0]    cur_i,
  output logic [SA_W-1:0]   cur_k,
  output logic [SA_W-1:0]   cur_l,
  // host readback
  input  logic [SLOT_W-1:0] rd_slot,
  output logic [I_W-1:0]    rd_i,
  output logic [SA_W-1:0]   rd_k,
  output logic [SA_W-1:0]   rd_l,
  output logic              rd_done,
  output logic              rd_active
);

  // Controller state codes this block reacts to; GET_DATA_x, EX and DONE
  // leave all internal state untouched apart from the find pulse clearing.
  localparam logic [2:0] c_ST_IDLE       = 3'd0;
  localparam logic [2:0] c_ST_GET_PARAM  = 3'd1;
  localparam logic [2:0] c_ST_WRITE_BACK = 3'd6;

  // Task table
  logic [NUM_SLOT-1:0] r_active;
  logic [NUM_SLOT-1:0] r_done;
  logic [I_W-1:0]      r_tab_i [NUM_SLOT];
  logic [SA_W-1:0]     r_tab_k [NUM_SLOT];
  logic [SA_W-1:0]     r_tab_l [NUM_SLOT];

  // Control and in-flight task registers
  logic [SLOT_W-1:0]   r_ptr;
  logic                r_is_start;
  logic                r_is_find;
  logic                r_is_occ;
  logic                r_is_finish;
  logic [SLOT_W-1:0]   r_cur_slot;
  logic [I_W-1:0]      r_cur_i;
  logic [SA_W-1:0]     r_cur_k;
  logic [SA_W-1:0]     r_cur_l;

  // Derived conditions
  logic w_is_idle;
  logic w_is_get_param;
  logic w_is_write_back;
  logic w_any_active;
  logic w_all_done;
  logic w_finish_cond;
  logic w_scan;
  logic w_eligible;
  logic w_take;
  logic w_load;

  assign w_is_idle       = (state == c_ST_IDLE);
  assign w_is_get_param  = (state == c_ST_GET_PARAM);
  assign w_is_write_back = (state == c_ST_WRITE_BACK);

  assign w_any_active  = |r_active;
  // Inactive slots are ignored: only active-but-not-done slots block finish.
  assign w_all_done    = ~|(r_active & ~r_done);
  assign w_finish_cond = w_is_get_param & w_any_active & w_all_done;

  // One slot is inspected per clock while looking for work.
  assign w_scan     = w_is_get_param & ~r_is_find & ~r_is_finish;
  assign w_eligible = r_active[r_ptr] & ~r_done[r_ptr];
  assign w_take     = w_scan & w_eligible;

  assign w_load     = w_is_idle & load_en;

  // Task table: host loads in IDLE, EX results land in WRITE_BACK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= '0;
      r_done   <= '0;
      for (int s = 0; s < NUM_SLOT; s++) begin
        r_tab_i[s] <= '0;
        r_tab_k[s] <= '0;
        r_tab_l[s] <= '0;
      end
    end else if (w_load) begin
      r_active[load_slot] <= 1'b1;
      r_done[load_slot]   <= 1'b0;
      r_tab_i[load_slot]  <= load_i;
      r_tab_k[load_slot]  <= load_k;
      r_tab_l[load_slot]  <= load_l;
    end else if (w_is_write_back) begin
      r_done[r_cur_slot]  <= wb_done;
      r_tab_i[r_cur_slot] <= wb_i;
      r_tab_k[r_cur_slot] <= wb_k;
      r_tab_l[r_cur_slot] <= wb_l;
    end
  end

  // Start level: armed in IDLE when there is work (including a same-cycle
  // load), dropped on the first clock the controller has left IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_start <= 1'b0;
    end else if (!w_is_idle) begin
      r_is_start <= 1'b0;
    end else if (start_req && (w_any_active || load_en)) begin
      r_is_start <= 1'b1;
    end
  end

  // Round-robin scan pointer and single-cycle find pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= '0;
      r_is_find <= 1'b0;
    end else begin
      r_is_find <= w_take;
      // Advancing past the taken slot is exactly slot+1 since slot == ptr.
      if (w_scan) begin
        r_ptr <= r_ptr + SLOT_W'(1);
      end
    end
  end

  // Sticky completion flag; only cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_finish <= 1'b0;
    end else if (w_finish_cond) begin
      r_is_finish <= 1'b1;
    end
  end

  // Capture the selected task; held until the next find.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_slot <= '0;
      r_cur_i    <= '0;
      r_cur_k    <= '0;
      r_cur_l    <= '0;
      r_is_occ   <= 1'b0;
    end else if (w_take) begin
      r_cur_slot <= r_ptr;
      r_cur_i    <= r_tab_i[r_ptr];
      r_cur_k    <= r_tab_k[r_ptr];
      r_cur_l    <= r_tab_l[r_ptr];
      r_is_occ   <= (r_tab_i[r_ptr] != '0);
    end
  end

  assign is_start           = r_is_start;
  assign is_find            = r_is_find;
  assign is_get_data_in_Occ = r_is_occ;
  assign is_finish          = r_is_finish;
  assign cur_slot           = r_cur_slot;
  assign cur_i              = r_cur_i;
  assign cur_k              = r_cur_k;
  assign cur_l              = r_cur_l;

  assign rd_i      = r_tab_i[rd_slot];
  assign rd_k      = r_tab_k[rd_slot];
  assign rd_l      = r_tab_l[rd_slot];
  assign rd_done   = r_done[rd_slot];
  assign rd_active = r_active[rd_slot];

endmodule
`default_nettype wire

// File: tb/tb_bwt_param_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bwt_param_scheduler
//  Description : Self-checking bench for bwt_param_scheduler: directed vector
//                table, hand-written corner sequences and a randomized run
//                against a behavioural task-table model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bwt_param_scheduler;

  localparam int NS = 8;
  localparam int SW = 3;
  localparam int IW = 7;
  localparam int AW = 32;

  localparam int ST_IDLE = 0;
  localparam int ST_GP   = 1;
  localparam int ST_GD1  = 2;
  localparam int ST_GD2  = 3;
  localparam int ST_GD3  = 4;
  localparam int ST_EX   = 5;
  localparam int ST_WB   = 6;
  localparam int ST_DONE = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    state;
  logic          load_en;
  logic [SW-1:0] load_slot;
  logic [IW-1:0] load_i;
  logic [AW-1:0] load_k, load_l;
  logic          start_req;
  logic [IW-1:0] wb_i;
  logic [AW-1:0] wb_k, wb_l;
  logic          wb_done;
  logic          is_start, is_find, is_get_data_in_Occ, is_finish;
  logic [SW-1:0] cur_slot;
  logic [IW-1:0] cur_i;
  logic [AW-1:0] cur_k, cur_l;
  logic [SW-1:0] rd_slot;
  logic [IW-1:0] rd_i;
  logic [AW-1:0] rd_k, rd_l;
  logic          rd_done, rd_active;

  int total = 0;
  int bad   = 0;

  bwt_param_scheduler #(.NUM_SLOT(NS), .I_W(IW), .SA_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .state(state),
    .load_en(load_en), .load_slot(load_slot), .load_i(load_i),
    .load_k(load_k), .load_l(load_l), .start_req(start_req),
    .wb_i(wb_i), .wb_k(wb_k), .wb_l(wb_l), .wb_done(wb_done),
    .is_start(is_start), .is_find(is_find),
    .is_get_data_in_Occ(is_get_data_in_Occ), .is_finish(is_finish),
    .cur_slot(cur_slot), .cur_i(cur_i), .cur_k(cur_k), .cur_l(cur_l),
    .rd_slot(rd_slot), .rd_i(rd_i), .rd_k(rd_k), .rd_l(rd_l),
    .rd_done(rd_done), .rd_active(rd_active)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    state = 3'(ST_IDLE); load_en = 0; load_slot = '0; load_i = '0;
    load_k = '0; load_l = '0; start_req = 0; wb_i = '0; wb_k = '0;
    wb_l = '0; wb_done = 0; rd_slot = '0;
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic [2:0]    st;
    logic          ld;
    logic [SW-1:0] lslot;
    logic [IW-1:0] li;
    logic [AW-1:0] lk, ll;
    logic          sr;
    logic [IW-1:0] wi;
    logic [AW-1:0] wk, wl;
    logic          wd;
    logic [SW-1:0] rs;
    logic          e_start, e_find, e_occ, e_fin;
    logic [SW-1:0] e_cslot;
    logic [IW-1:0] e_ci;
    logic [IW-1:0] e_ri;
    logic [AW-1:0] e_rk, e_rl;
    logic          e_rdone, e_ract;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int st, ld, lslot, li, input logic [AW-1:0] lk, ll,
                     input int sr, wi, input logic [AW-1:0] wk, wl, input int wd,
                     input int es, ef, eo, efin, ecs, eci, eri,
                     input logic [AW-1:0] erk, erl, input int erd, era);
    vec_t v;
    v.st = 3'(st); v.ld = 1'(ld); v.lslot = SW'(lslot); v.li = IW'(li);
    v.lk = lk; v.ll = ll; v.sr = 1'(sr); v.wi = IW'(wi); v.wk = wk; v.wl = wl;
    v.wd = 1'(wd); v.rs = SW'(3);
    v.e_start = 1'(es); v.e_find = 1'(ef); v.e_occ = 1'(eo); v.e_fin = 1'(efin);
    v.e_cslot = SW'(ecs); v.e_ci = IW'(eci); v.e_ri = IW'(eri);
    v.e_rk = erk; v.e_rl = erl; v.e_rdone = 1'(erd); v.e_ract = 1'(era);
    vq.push_back(v);
  endtask

  // ---------------------------------------------------------------- model
  bit            m_active [NS];
  bit            m_done   [NS];
  logic [IW-1:0] m_i [NS];
  logic [AW-1:0] m_k [NS];
  logic [AW-1:0] m_l [NS];
  int            m_ptr;
  bit            m_start, m_find, m_occ, m_finish;
  int            m_cslot;
  logic [IW-1:0] m_ci;
  logic [AW-1:0] m_ck, m_cl;

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_active[s] = 0; m_done[s] = 0; m_i[s] = '0; m_k[s] = '0; m_l[s] = '0;
    end
    m_ptr = 0; m_start = 0; m_find = 0; m_occ = 0; m_finish = 0;
    m_cslot = 0; m_ci = '0; m_ck = '0; m_cl = '0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_edge();
    int  n_act  = 0;
    int  n_pend = 0;
    bit  nxt_start, nxt_find, nxt_fin;
    for (int s = 0; s < NS; s++) begin
      if (m_active[s]) n_act++;
      if (m_active[s] && !m_done[s]) n_pend++;
    end
    nxt_find  = 0;
    nxt_fin   = m_finish || (state == ST_GP && n_act > 0 && n_pend == 0);
    if (state == ST_IDLE)
      nxt_start = m_start || (start_req && (n_act > 0 || load_en));
    else
      nxt_start = 0;
    if (state == ST_GP && !m_find && !m_finish) begin
      if (m_active[m_ptr] && !m_done[m_ptr]) begin
        nxt_find = 1;
        m_cslot = m_ptr;
        m_ci = m_i[m_ptr]; m_ck = m_k[m_ptr]; m_cl = m_l[m_ptr];
        m_occ = (m_i[m_ptr] != 0);
      end
      m_ptr = (m_ptr + 1) % NS;
    end
    if (state == ST_IDLE && load_en) begin
      m_active[load_slot] = 1; m_done[load_slot] = 0;
      m_i[load_slot] = load_i; m_k[load_slot] = load_k; m_l[load_slot] = load_l;
    end else if (state == ST_WB) begin
      m_done[m_cslot] = wb_done;
      m_i[m_cslot] = wb_i; m_k[m_cslot] = wb_k; m_l[m_cslot] = wb_l;
    end
    m_start = nxt_start; m_find = nxt_find; m_finish = nxt_fin;
  endtask

  task automatic check_model(input int cyc);
    chk($sformatf("rnd%0d.is_start", cyc), 64'(is_start), 64'(m_start));
    chk($sformatf("rnd%0d.is_find", cyc), 64'(is_find), 64'(m_find));
    chk($sformatf("rnd%0d.occ", cyc), 64'(is_get_data_in_Occ), 64'(m_occ));
    chk($sformatf("rnd%0d.is_finish", cyc), 64'(is_finish), 64'(m_finish));
    chk($sformatf("rnd%0d.cur_slot", cyc), 64'(cur_slot), 64'(m_cslot));
    chk($sformatf("rnd%0d.cur_i", cyc), 64'(cur_i), 64'(m_ci));
    chk($sformatf("rnd%0d.cur_k", cyc), 64'(cur_k), 64'(m_ck));
    chk($sformatf("rnd%0d.cur_l", cyc), 64'(cur_l), 64'(m_cl));
    chk($sformatf("rnd%0d.rd_i", cyc), 64'(rd_i), 64'(m_i[rd_slot]));
    chk($sformatf("rnd%0d.rd_k", cyc), 64'(rd_k), 64'(m_k[rd_slot]));
    chk($sformatf("rnd%0d.rd_l", cyc), 64'(rd_l), 64'(m_l[rd_slot]));
    chk($sformatf("rnd%0d.rd_done", cyc), 64'(rd_done), 64'(m_done[rd_slot]));
    chk($sformatf("rnd%0d.rd_active", cyc), 64'(rd_active), 64'(m_active[rd_slot]));
  endtask

  // ---------------------------------------------------------------- test
  initial begin
    vec_t v;
    bit   found;
    int   r;

    clr_in();
    rst_n = 0;
    step(); step();
    // outputs and readback during reset
    chk("reset.is_start", 64'(is_start), 64'(0));
    chk("reset.is_find", 64'(is_find), 64'(0));
    chk("reset.occ", 64'(is_get_data_in_Occ), 64'(0));
    chk("reset.is_finish", 64'(is_finish), 64'(0));
    chk("reset.cur_k", 64'(cur_k), 64'(0));
    rst_n = 1;
    step();
    for (int s = 0; s < NS; s++) begin
      rd_slot = SW'(s);
      #1;
      chk($sformatf("reset.rd_active%0d", s), 64'(rd_active), 64'(0));
    end

    // Directed table: single task with Occ, ignored load, write-back, finish.
    add(ST_IDLE,1,3,5,0,99, 0,0,0,0,0, 0,0,0,0,0,0, 5,0,99,0,1);
    add(ST_IDLE,0,0,0,0,0,  1,0,0,0,0, 1,0,0,0,0,0, 5,0,99,0,1);
    add(ST_IDLE,0,0,0,0,0,  0,0,0,0,0, 1,0,0,0,0,0, 5,0,99,0,1);
    for (int n = 0; n < 3; n++)
      add(ST_GP,0,0,0,0,0,  0,0,0,0,0, 0,0,0,0,0,0, 5,0,99,0,1);
    add(ST_GP,0,0,0,0,0,    0,0,0,0,0, 0,1,1,0,3,5, 5,0,99,0,1);
    add(ST_GD1,0,0,0,0,0,   0,0,0,0,0, 0,0,1,0,3,5, 5,0,99,0,1);
    add(ST_EX,1,3,9,9,9,    0,0,0,0,0, 0,0,1,0,3,5, 5,0,99,0,1);
    add(ST_WB,0,0,0,0,0,    0,4,10,20,0, 0,0,1,0,3,5, 4,10,20,0,1);
    for (int n = 0; n < 7; n++)
      add(ST_GP,0,0,0,0,0,  0,0,0,0,0, 0,0,1,0,3,5, 4,10,20,0,1);
    add(ST_GP,0,0,0,0,0,    0,0,0,0,0, 0,1,1,0,3,4, 4,10,20,0,1);
    add(ST_GD1,0,0,0,0,0,   0,0,0,0,0, 0,0,1,0,3,4, 4,10,20,0,1);
    add(ST_WB,0,0,0,0,0,    0,3,10,5,1, 0,0,1,0,3,4, 3,10,5,1,1);
    add(ST_GP,0,0,0,0,0,    0,0,0,0,0, 0,0,1,1,3,4, 3,10,5,1,1);
    add(ST_GP,0,0,0,0,0,    0,0,0,0,0, 0,0,1,1,3,4, 3,10,5,1,1);
    add(ST_DONE,0,0,0,0,0,  0,0,0,0,0, 0,0,1,1,3,4, 3,10,5,1,1);

    for (int n = 0; n < vq.size(); n++) begin
      v = vq[n];
      state = v.st; load_en = v.ld; load_slot = v.lslot; load_i = v.li;
      load_k = v.lk; load_l = v.ll; start_req = v.sr; wb_i = v.wi;
      wb_k = v.wk; wb_l = v.wl; wb_done = v.wd; rd_slot = v.rs;
      step();
      chk($sformatf("vec%0d.is_start", n), 64'(is_start), 64'(v.e_start));
      chk($sformatf("vec%0d.is_find", n), 64'(is_find), 64'(v.e_find));
      chk($sformatf("vec%0d.occ", n), 64'(is_get_data_in_Occ), 64'(v.e_occ));
      chk($sformatf("vec%0d.is_finish", n), 64'(is_finish), 64'(v.e_fin));
      chk($sformatf("vec%0d.cur_slot", n), 64'(cur_slot), 64'(v.e_cslot));
      chk($sformatf("vec%0d.cur_i", n), 64'(cur_i), 64'(v.e_ci));
      chk($sformatf("vec%0d.rd_i", n), 64'(rd_i), 64'(v.e_ri));
      chk($sformatf("vec%0d.rd_k", n), 64'(rd_k), 64'(v.e_rk));
      chk($sformatf("vec%0d.rd_l", n), 64'(rd_l), 64'(v.e_rl));
      chk($sformatf("vec%0d.rd_done", n), 64'(rd_done), 64'(v.e_rdone));
      chk($sformatf("vec%0d.rd_active", n), 64'(rd_active), 64'(v.e_ract));
    end

    // Asynchronous reset in the middle of a cycle with the table populated.
    clr_in();
    state = 3'(ST_GP);
    step();
    #2;
    rst_n = 0;
    #1;
    chk("areset.is_finish", 64'(is_finish), 64'(0));
    chk("areset.occ", 64'(is_get_data_in_Occ), 64'(0));
    chk("areset.cur_slot", 64'(cur_slot), 64'(0));
    chk("areset.cur_i", 64'(cur_i), 64'(0));
    for (int s = 0; s < NS; s++) begin
      rd_slot = SW'(s);
      #0.5;
      chk($sformatf("areset.rd_active%0d", s), 64'(rd_active), 64'(0));
    end
    step();
    rst_n = 1;
    state = 3'(ST_IDLE);

    // Start with an empty table is ignored; a same-cycle load enables it.
    start_req = 1;
    step();
    chk("empty_start.is_start", 64'(is_start), 64'(0));
    load_en = 1; load_slot = SW'(5); load_i = IW'(1);
    step();
    chk("load_start.is_start", 64'(is_start), 64'(1));
    clr_in();
    rst_n = 0;
    step();
    rst_n = 1;

    // Round-robin over slots 0 (i=2) and 1 (i=0).
    load_en = 1; load_slot = SW'(0); load_i = IW'(2); load_k = 1; load_l = 2;
    step();
    load_slot = SW'(1); load_i = IW'(0); load_k = 3; load_l = 4; start_req = 1;
    step();
    clr_in();
    for (int vis = 0; vis < 4; vis++) begin
      state = 3'(ST_GP);
      found = 0;
      for (int c = 0; c < 2 * NS && !found; c++) begin
        step();
        if (is_find) found = 1;
      end
      chk($sformatf("rr%0d.find_seen", vis), 64'(found), 64'(1));
      chk($sformatf("rr%0d.slot", vis), 64'(cur_slot), 64'(vis % 2));
      chk($sformatf("rr%0d.occ", vis), 64'(is_get_data_in_Occ), 64'(vis % 2 == 0));
      chk($sformatf("rr%0d.cur_i", vis), 64'(cur_i), 64'((vis % 2 == 0) ? 2 : 0));
      state = 3'(ST_GD1);
      step();
      chk($sformatf("rr%0d.find_pulse", vis), 64'(is_find), 64'(0));
      state = 3'(ST_WB);
      wb_i = IW'((vis % 2 == 0) ? 2 : 0);
      wb_k = (vis % 2 == 0) ? 1 : 3;
      wb_l = (vis % 2 == 0) ? 2 : 4;
      wb_done = 0;
      step();
    end

    // Randomized run against the task-table model.
    for (int ep = 0; ep < 8; ep++) begin
      clr_in();
      rst_n = 0;
      model_reset();
      step();
      rst_n = 1;
      for (int cyc = 0; cyc < 150; cyc++) begin
        if (cyc < 10) begin
          state = 3'(ST_IDLE);
        end else begin
          r = int'($urandom_range(0, 9));
          case (r)
            0, 1, 2, 3: state = 3'(ST_GP);
            4:          state = 3'(ST_GD1);
            5:          state = 3'($urandom_range(ST_GD2, ST_EX));
            6, 7:       state = 3'(ST_WB);
            8:          state = 3'(ST_IDLE);
            default:    state = 3'(ST_DONE);
          endcase
        end
        load_en   = (ep != 0) && ($urandom_range(0, 2) == 0);
        load_slot = SW'($urandom);
        load_i    = ($urandom_range(0, 3) == 0) ? '0 : IW'($urandom);
        load_k    = $urandom;
        load_l    = $urandom;
        start_req = ($urandom_range(0, 3) == 0);
        wb_i      = IW'($urandom);
        wb_k      = $urandom;
        wb_l      = $urandom;
        wb_done   = ($urandom_range(0, 3) == 0);
        rd_slot   = SW'($urandom);
        model_edge();
        step();
        check_model(ep * 1000 + cyc);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
